spiram_port_arbiter: RTL and testbench
======================================

Name: spiram_port_arbiter

Overview:
Two-port round-robin arbiter and transaction sequencer in front of the memory-mapped SPI RAM controller (rd/wr strobe, rbusy/wbusy interface). Each requester port (port 0, typically the CPU data port; port 1, a secondary master such as a loader/DMA) issues single-word read/write requests with a req/ack handshake. The block serializes the requests and drives the strobe/busy protocol toward the SPI RAM controller. It returns read data, and reports an error if the controller never responds.

Parameters:
TIMEOUT_CYCLES, 1024, max clk cycles per phase (strobe-to-busy, busy-to-idle) before abort with error; 1..65535
CNT_W, 16, width of timeout counter

Ports:
clk  in  1  system clock; all state on posedge
reset  in  1  reset, synchronous, active-low
m0_req  in  1  port 0 request; held with payload stable until m0_ack
m0_we  in  1  port 0: 1 = write, 0 = read
m0_addr  in  16  port 0 word address
m0_wdata  in  32  port 0 write data
m0_rdata  out  32  port 0 read data, valid when m0_ack & !m0_err & read
m0_ack  out  1  port 0 one-cycle completion pulse
m0_err  out  1  port 0 timeout flag, valid with m0_ack
m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack, m1_err  same as port 0, for port 1
mem_rd  out  1  read strobe to SPI RAM controller
mem_wr  out  1  write strobe to SPI RAM controller
mem_addr  out  16  latched word address
mem_wdata  out  32  latched write data
mem_rdata  in  32  read data from controller
mem_rbusy  in  1  controller read busy
mem_wbusy  in  1  controller write busy

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; mem_rd=mem_wr=0; mem_addr=0; mem_wdata=0; m0/m1_rdata=0; m0/m1_ack=0; m0/m1_err=0; timeout cnt=0; last_grant=1 (port 0 wins first contest). Reset mid-transaction aborts: no ack is issued, strobes drop at that edge.
- busy = mem_rbusy | mem_wbusy.
- IDLE: if any req, grant: only one requesting -> that one; both -> the port != last_grant. Latch we/addr/wdata of the granted port into mem_* regs and grant id; cnt=0; -> ISSUE. No req -> stay.
- ISSUE: mem_rd = !we, mem_wr = we; the strobe is held until busy is sampled 1 (the controller may still be in its START cycle). On busy==1: drop strobe the same edge, cnt=0, -> WAIT. Else cnt++; cnt==TIMEOUT_CYCLES-1 -> drop strobe, err=1, -> DONE.
- WAIT: strobes 0. On busy==0: if read, capture mem_rdata into granted port's rdata; err=0; -> DONE. Else cnt++; timeout as in ISSUE -> DONE with err=1, rdata unchanged.
- DONE: granted port's ack=1 for exactly this cycle, err driven with it (err holds until next ack of that port); last_grant=grant; -> IDLE. The other port's ack stays 0.
- Min latency, req rising to ack: IDLE(1) + ISSUE(>=1) + WAIT(>=1) + DONE = ack no earlier than 3rd edge after req sampled. Actual latency is dominated by SPI transfer length.
- Back-to-back: requester may keep req high after ack with new payload; it is sampled again in IDLE the next cycle. With both ports continuously requesting, grants strictly alternate.
- req dropped mid-transaction: transaction completes; ack still pulses (ignored by requester); no retry.
- Writes never modify any rdata register. mem_wdata carries the full 32 bits; the downstream width is the controller's concern.
- Never both mem_rd and mem_wr high; never a strobe outside ISSUE.
- Unreachable state encodings -> IDLE.

Test Plan:
- Port 0 read addr 0x0012, controller model raises rbusy 2 cycles after mem_rd, holds 40 cycles, mem_rdata=0xDEADBEEF -> mem_rd high until rbusy seen, m0_ack one pulse, m0_rdata=0xDEADBEEF, m0_err=0, m1_ack never.
- Port 1 write addr 0x00A5 data 0x000000C3 -> mem_wr=1, mem_addr=0x00A5, mem_wdata=0x000000C3; m1_ack after wbusy falls; m1_rdata unchanged (0).
- Both ports request the same cycle, held for 4 transactions -> grant order 0,1,0,1; each ack pulses once per transaction.
- Controller model never asserts busy, TIMEOUT_CYCLES=8 -> strobe drops after 8 ISSUE cycles; m0_ack=1 with m0_err=1; next request completes normally with m0_err=0.
- Busy stuck high after strobe, TIMEOUT_CYCLES=8 -> ack with err=1 after 8 WAIT cycles; rdata unchanged.
- Reset asserted during WAIT -> next edge all outputs at reset values, no ack; after release, port 0 request serviced first.

Source files
------------

// File: rtl/spiram_port_arbiter.sv
// spiram_port_arbiter: two-port round-robin arbiter and single-word transaction
// sequencer driving the rd/wr strobe and rbusy/wbusy handshake of the SPI RAM
// controller. Each phase (strobe-to-busy, busy-to-idle) is bounded by a
// timeout that completes the transaction with an error flag.
module spiram_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset,
  // port 0
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [15:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,
  // port 1
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [15:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  // SPI RAM controller side
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rbusy,
  input  logic        mem_wbusy
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grant_q, grant_d;
  logic             we_q, we_d;
  logic             last_grant_q, last_grant_d;

  logic             mem_rd_d, mem_wr_d;
  logic [AW-1:0]    mem_addr_d;
  logic [DW-1:0]    mem_wdata_d;
  logic [DW-1:0]    m0_rdata_d, m1_rdata_d;
  logic             m0_ack_d, m1_ack_d;
  logic             m0_err_d, m1_err_d;

  logic             busy_c;
  logic             timeout_c;
  logic             pick_c;
  logic             pick_we_c;
  logic [AW-1:0]    pick_addr_c;
  logic [DW-1:0]    pick_wdata_c;

  assign busy_c    = mem_rbusy | mem_wbusy;
  assign timeout_c = (cnt_q == CNT_LAST);

  // Round-robin pick: a lone requester wins, a contest goes to the port not granted last.
  assign pick_c       = (m0_req & m1_req) ? ~last_grant_q : m1_req;
  assign pick_we_c    = pick_c ? m1_we    : m0_we;
  assign pick_addr_c  = pick_c ? m1_addr  : m0_addr;
  assign pick_wdata_c = pick_c ? m1_wdata : m0_wdata;

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    we_d         = we_q;
    last_grant_d = last_grant_q;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    m0_rdata_d   = m0_rdata;
    m1_rdata_d   = m1_rdata;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    m0_err_d     = m0_err;
    m1_err_d     = m1_err;

    case (state_q)
      ST_IDLE: begin
        if (m0_req | m1_req) begin
          grant_d     = pick_c;
          we_d        = pick_we_c;
          mem_addr_d  = pick_addr_c;
          mem_wdata_d = pick_wdata_c;
          cnt_d       = '0;
          mem_rd_d    = ~pick_we_c;
          mem_wr_d    = pick_we_c;
          state_d     = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (busy_c) begin
          // controller has accepted the strobe; release it on this edge
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else if (timeout_c) begin
          if (grant_q) begin
            m1_ack_d = 1'b1;
            m1_err_d = 1'b1;
          end else begin
            m0_ack_d = 1'b1;
            m0_err_d = 1'b1;
          end
          state_d = ST_DONE;
        end else begin
          // hold the strobe: the controller may still be in its start cycle
          cnt_d    = cnt_q + CNT_W'(1);
          mem_rd_d = ~we_q;
          mem_wr_d = we_q;
        end
      end

      ST_WAIT: begin
        if (!busy_c) begin
          if (grant_q) begin
            m1_ack_d = 1'b1;
            m1_err_d = 1'b0;
            if (!we_q) m1_rdata_d = mem_rdata;
          end else begin
            m0_ack_d = 1'b1;
            m0_err_d = 1'b0;
            if (!we_q) m0_rdata_d = mem_rdata;
          end
          state_d = ST_DONE;
        end else if (timeout_c) begin
          if (grant_q) begin
            m1_ack_d = 1'b1;
            m1_err_d = 1'b1;
          end else begin
            m0_ack_d = 1'b1;
            m0_err_d = 1'b1;
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        // ack is visible during this cycle; remember the winner for fairness
        last_grant_d = grant_q;
        state_d      = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      grant_q      <= 1'b0;
      we_q         <= 1'b0;
      last_grant_q <= 1'b1;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      m0_err       <= 1'b0;
      m1_err       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      last_grant_q <= last_grant_d;
      mem_rd       <= mem_rd_d;
      mem_wr       <= mem_wr_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      m0_rdata     <= m0_rdata_d;
      m1_rdata     <= m1_rdata_d;
      m0_ack       <= m0_ack_d;
      m1_ack       <= m1_ack_d;
      m0_err       <= m0_err_d;
      m1_err       <= m1_err_d;
    end
  end

endmodule

// File: tb/tb_spiram_port_arbiter.sv
// tb_spiram_port_arbiter: directed plus randomized transactions against a
// behavioural SPI RAM controller and a transaction-level reference model.
`timescale 1ns/1ps
module tb_spiram_port_arbiter;

  localparam int TO     = 48;
  localparam int BUDGET = 400;

  typedef enum int {CM_NORMAL, CM_NEVER, CM_STUCK} cmode_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [15:0] m0_addr = '0;
  logic [31:0] m0_wdata = '0;
  logic [31:0] m0_rdata;
  logic        m0_ack, m0_err;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [15:0] m1_addr = '0;
  logic [31:0] m1_wdata = '0;
  logic [31:0] m1_rdata;
  logic        m1_ack, m1_err;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rbusy, mem_wbusy;

  spiram_port_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy)
  );

  always #5 clk = ~clk;

  // Seeded memory image shared by the controller model and the reference model.
  function automatic logic [31:0] def_word(input logic [15:0] a);
    return (a == 16'h0012) ? 32'hDEADBEEF : {~a, a};
  endfunction

  // Controller model: sees a strobe, waits ctl_lat cycles, then is busy for ctl_hold+1 cycles.
  cmode_t      ctl_mode = CM_NORMAL;
  int          ctl_lat  = 0;
  int          ctl_hold = 0;
  int          ctl_phase;
  int          ctl_cnt;
  logic        ctl_rd;
  logic [31:0] ctl_mem [0:255];

  always @(posedge clk) begin
    if (!reset) begin
      ctl_phase <= 0;
      ctl_cnt   <= 0;
      ctl_rd    <= 1'b0;
      mem_rbusy <= 1'b0;
      mem_wbusy <= 1'b0;
      mem_rdata <= '0;
      for (int i = 0; i < 256; i++) ctl_mem[i] <= def_word(16'(i));
    end else begin
      case (ctl_phase)
        0: if ((mem_rd || mem_wr) && ctl_mode != CM_NEVER) begin
             ctl_phase <= 1;
             ctl_cnt   <= ctl_lat;
             ctl_rd    <= mem_rd;
           end
        1: if (ctl_cnt == 0) begin
             if (ctl_rd) begin
               mem_rbusy <= 1'b1;
               mem_rdata <= ctl_mem[mem_addr[7:0]];
             end else begin
               mem_wbusy <= 1'b1;
               ctl_mem[mem_addr[7:0]] <= mem_wdata;
             end
             ctl_cnt   <= ctl_hold;
             ctl_phase <= 2;
           end else ctl_cnt <= ctl_cnt - 1;
        default: if (ctl_mode != CM_STUCK) begin
             if (ctl_cnt == 0) begin
               mem_rbusy <= 1'b0;
               mem_wbusy <= 1'b0;
               ctl_phase <= 0;
             end else ctl_cnt <= ctl_cnt - 1;
           end
      endcase
    end
  end

  // Reference model state: per-port visible results, arbitration history, memory contents.
  int          checks = 0;
  int          failures = 0;
  int          exp_last;
  logic [31:0] exp_rdata [2];
  logic        exp_err [2];
  logic [31:0] ref_mem [0:255];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    exp_last = 1;
    for (int p = 0; p < 2; p++) begin
      exp_rdata[p] = '0;
      exp_err[p]   = 1'b0;
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = def_word(16'(i));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_rd"},    mem_rd,    0);
    check({tag, "_mem_wr"},    mem_wr,    0);
    check({tag, "_mem_addr"},  mem_addr,  0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_m0_rdata"},  m0_rdata,  0);
    check({tag, "_m1_rdata"},  m1_rdata,  0);
    check({tag, "_acks"},      {m1_ack, m0_ack}, 0);
    check({tag, "_errs"},      {m1_err, m0_err}, 0);
  endtask

  // One request round: r0/r1 select requesting ports; each drops its req on its ack.
  task automatic txn(input string tag, input logic r0, input logic r1,
                     input logic we0, input logic we1,
                     input logic [15:0] a0, input logic [15:0] a1,
                     input logic [31:0] d0, input logic [31:0] d1,
                     input cmode_t mode, input int lat, input int hold);
    int          order[$];
    logic        we [2];
    logic [15:0] a [2];
    logic [31:0] d [2];
    int          cyc, strobe_cyc, cur, served, exp_lat, exp_strobe;
    bit          seen;
    logic        err_exp;
    we[0] = we0; we[1] = we1; a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
    ctl_mode = mode; ctl_lat = lat; ctl_hold = hold;
    if (r0 && r1) begin
      cur = (exp_last == 1) ? 0 : 1;
      order.push_back(cur);
      order.push_back(1 - cur);
    end else order.push_back(r1 ? 1 : 0);
    case (mode)
      CM_NEVER: begin exp_strobe = TO;      exp_lat = TO + 1;            err_exp = 1'b1; end
      CM_STUCK: begin exp_strobe = lat + 3; exp_lat = lat + TO + 4;      err_exp = 1'b1; end
      default:  begin exp_strobe = lat + 3; exp_lat = lat + hold + 5;    err_exp = 1'b0; end
    endcase
    m0_req = r0; m0_we = we0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = we1; m1_addr = a1; m1_wdata = d1;
    cyc = 0; strobe_cyc = 0; served = 0; seen = 1'b0;
    while (order.size() != 0 && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      cur = order[0];
      check({tag, "_excl"}, {31'd0, mem_rd & mem_wr}, 0);
      if (mem_rd || mem_wr) begin
        strobe_cyc++;
        if (!seen) begin
          seen = 1'b1;
          check({tag, "_addr"}, mem_addr, a[cur]);
          check({tag, "_kind"}, {mem_wr, mem_rd}, we[cur] ? 2'b10 : 2'b01);
          if (we[cur]) check({tag, "_wdata"}, mem_wdata, d[cur]);
        end
      end
      if (m0_ack || m1_ack) begin
        check({tag, "_ack_port"}, {m1_ack, m0_ack}, (cur == 1) ? 2'b10 : 2'b01);
        if (!err_exp && !we[cur]) exp_rdata[cur] = ref_mem[a[cur][7:0]];
        if (we[cur] && mode != CM_NEVER) ref_mem[a[cur][7:0]] = d[cur];
        exp_err[cur] = err_exp;
        exp_last     = cur;
        check({tag, "_m0_rdata"}, m0_rdata, exp_rdata[0]);
        check({tag, "_m1_rdata"}, m1_rdata, exp_rdata[1]);
        check({tag, "_m0_err"},   m0_err,   exp_err[0]);
        check({tag, "_m1_err"},   m1_err,   exp_err[1]);
        check({tag, "_strobe_cycles"}, strobe_cyc, exp_strobe);
        if (served == 0) check({tag, "_latency"}, cyc, exp_lat);
        if (cur == 0) m0_req = 1'b0; else m1_req = 1'b0;
        void'(order.pop_front());
        served++;
        seen = 1'b0;
        strobe_cyc = 0;
      end
    end
    if (order.size() != 0) check({tag, "_no_ack_within_budget"}, order.size(), 0);
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    check({tag, "_ack_single_pulse"}, {m1_ack, m0_ack}, 0);
  endtask

  initial begin
    int   v, waited;
    bit   seen;
    logic r0, r1;
    reset_model();

    // reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);

    // port 0 read, busy 2 cycles after strobe, held 40 cycles
    txn("rd0_deadbeef", 1, 0, 0, 0, 16'h0012, 16'h0, 32'h0, 32'h0, CM_NORMAL, 0, 39);
    // port 1 write
    txn("wr1_a5", 0, 1, 0, 1, 16'h0, 16'h00A5, 32'h0, 32'h000000C3, CM_NORMAL, 1, 5);
    // read back written word via port 0
    txn("rd0_a5", 1, 0, 0, 0, 16'h00A5, 16'h0, 32'h0, 32'h0, CM_NORMAL, 2, 3);
    // contested requests: two rounds of both ports requesting
    txn("both_a", 1, 1, 0, 1, 16'h0003, 16'h0004, 32'h0, 32'h11112222, CM_NORMAL, 0, 2);
    txn("both_b", 1, 1, 1, 0, 16'h0005, 16'h0004, 32'h33334444, 32'h0, CM_NORMAL, 1, 0);

    // controller never answers: strobe timeout, then a clean transaction
    txn("never0", 1, 0, 0, 0, 16'h0007, 16'h0, 32'h0, 32'h0, CM_NEVER, 0, 0);
    txn("after_never0", 1, 0, 0, 0, 16'h0007, 16'h0, 32'h0, 32'h0, CM_NORMAL, 0, 1);

    // busy stuck high: wait-phase timeout, rdata untouched
    txn("stuck1", 0, 1, 0, 0, 16'h0, 16'h0012, 32'h0, 32'h0, CM_STUCK, 0, 0);
    ctl_mode = CM_NORMAL;
    repeat (3) @(negedge clk);
    txn("after_stuck1", 0, 1, 0, 1, 16'h0, 16'h0009, 32'h0, 32'hCAFEF00D, CM_NORMAL, 0, 2);

    // reset asserted while the transaction sits in WAIT
    ctl_mode = CM_NORMAL; ctl_lat = 0; ctl_hold = 30;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0033;
    waited = 0; seen = 1'b0;
    while (waited < BUDGET && !(seen && !mem_rd)) begin
      @(negedge clk);
      waited++;
      if (mem_rd) seen = 1'b1;
    end
    check("rstwait_reached_wait", (waited < BUDGET) ? 1 : 0, 1);
    @(negedge clk);
    check("rstwait_no_early_ack", {m1_ack, m0_ack}, 0);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("rstwait");
    m0_req = 1'b0;
    reset_model();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rstwait_post_ack", {m1_ack, m0_ack}, 0);
    txn("after_reset_both", 1, 1, 0, 0, 16'h0012, 16'h0009, 32'h0, 32'h0, CM_NORMAL, 0, 1);

    // randomized traffic over a small address window so reads hit earlier writes
    for (int it = 0; it < 40; it++) begin
      v  = int'($urandom_range(1, 3));
      r0 = v[0];
      r1 = v[1];
      txn("rand", r0, r1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)),
          $urandom, $urandom, CM_NORMAL,
          int'($urandom_range(0, 3)), int'($urandom_range(0, 12)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
